lsu_thread: RTL

- Per-thread load/store unit: the memory-side counterpart of the core scheduler's WAIT/UPDATE handshake.
- Watches core_state and decoded memory-enable controls, and issues one read or write to data memory per instruction.
- Reports progress on lsu_state; the scheduler polls lsu_state before leaving WAIT.
- One instance per thread in each compute core, between the register file (rs/rt) and the data-memory controller channel.

---
 rtl/lsu_thread.sv | 130 +++++++++++++
 1 files changed

// File: rtl/lsu_thread.sv
// Per-thread load/store unit: turns one LDR/STR per instruction into a single
// data-memory request and reports progress to the scheduler on lsu_state.
module lsu_thread #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [ADDR_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        REQUESTING = 2'b01,
        WAITING    = 2'b10,
        DONE       = 2'b11
    } lsu_state_e;

    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    lsu_state_e           state_q, state_d;
    logic                 is_read_q, is_read_d;
    logic                 read_valid_q, read_valid_d;
    logic [ADDR_BITS-1:0] read_addr_q, read_addr_d;
    logic                 write_valid_q, write_valid_d;
    logic [ADDR_BITS-1:0] write_addr_q, write_addr_d;
    logic [DATA_BITS-1:0] write_data_q, write_data_d;
    logic [DATA_BITS-1:0] lsu_out_q, lsu_out_d;

    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a signal unassigned
        // (otherwise synthesis would infer a latch).
        state_d       = state_q;
        is_read_d     = is_read_q;
        read_valid_d  = read_valid_q;
        read_addr_d   = read_addr_q;
        write_valid_d = write_valid_q;
        write_addr_d  = write_addr_q;
        write_data_d  = write_data_q;
        lsu_out_d     = lsu_out_q;

        unique case (state_q)
            IDLE: begin
                if (core_state == CORE_REQUEST && enable &&
                    (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                    // Read has priority when both enables are set.
                    is_read_d = decoded_mem_read_enable;
                    state_d   = REQUESTING;
                end
            end
            REQUESTING: begin
                if (is_read_q) begin
                    read_valid_d = 1'b1;
                    read_addr_d  = rs;
                end else begin
                    write_valid_d = 1'b1;
                    write_addr_d  = rs;
                    write_data_d  = rt;
                end
                state_d = WAITING;
            end
            WAITING: begin
                if (is_read_q && mem_read_ready) begin
                    read_valid_d = 1'b0;
                    lsu_out_d    = mem_read_data;
                    state_d      = DONE;
                end else if (!is_read_q && mem_write_ready) begin
                    write_valid_d = 1'b0;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (core_state == CORE_UPDATE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the asynchronous reset clears all of them, abandoning
    // any request in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            is_read_q     <= 1'b0;
            read_valid_q  <= 1'b0;
            read_addr_q   <= '0;
            write_valid_q <= 1'b0;
            write_addr_q  <= '0;
            write_data_q  <= '0;
            lsu_out_q     <= '0;
        end else begin
            state_q       <= state_d;
            is_read_q     <= is_read_d;
            read_valid_q  <= read_valid_d;
            read_addr_q   <= read_addr_d;
            write_valid_q <= write_valid_d;
            write_addr_q  <= write_addr_d;
            write_data_q  <= write_data_d;
            lsu_out_q     <= lsu_out_d;
        end
    end

    assign mem_read_valid    = read_valid_q;
    assign mem_read_address  = read_addr_q;
    assign mem_write_valid   = write_valid_q;
    assign mem_write_address = write_addr_q;
    assign mem_write_data    = write_data_q;
    assign lsu_state         = state_q;
    assign lsu_out           = lsu_out_q;

endmodule
